// File: rtl/core_wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter.
//  - CORE_XLEN / CORE_RFIDX_WIDTH: default data and register-index widths.
//  - wb_state_e: arbiter state encoding (EMPTY = no buffered ALU entry, HELD = one buffered).
// Optional feature macro used by core_wb_arbiter: CORE_WB_FWD_EN.
package core_wb_arbiter_pkg;

  localparam int CORE_XLEN        = 32;
  localparam int CORE_RFIDX_WIDTH = 5;

  typedef enum logic {
    WB_ST_EMPTY = 1'b0,
    WB_ST_HELD  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/core_wb_skid.sv
// core_wb_skid: 1-entry holding register for a writeback slot (wen/idx/dat).
// Ports:
//  clk, rst            core clock, asynchronous active-high reset
//  load_i              capture wen_i/idx_i/dat_i (wins over clear_i)
//  clear_i             empty the entry
//  wen_i/idx_i/dat_i   entry to capture
//  wen_o/idx_o/dat_o   stored entry
module core_wb_skid
  import core_wb_arbiter_pkg::*;
#(
  parameter int XLEN    = CORE_XLEN,
  parameter int RFIDX_W = CORE_RFIDX_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic               wen_i,
  input  logic [RFIDX_W-1:0] idx_i,
  input  logic [XLEN-1:0]    dat_i,
  output logic               wen_o,
  output logic [RFIDX_W-1:0] idx_o,
  output logic [XLEN-1:0]    dat_o
);

  logic               wen_q;
  logic [RFIDX_W-1:0] idx_q;
  logic [XLEN-1:0]    dat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q <= 1'b0;
      idx_q <= '0;
      dat_q <= '0;
    end else if (load_i) begin
      wen_q <= wen_i;
      idx_q <= idx_i;
      dat_q <= dat_i;
    end else if (clear_i) begin
      wen_q <= 1'b0;
      idx_q <= '0;
      dat_q <= '0;
    end
  end

  assign wen_o = wen_q;
  assign idx_o = idx_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/core_wb_arbiter.sv
// core_wb_arbiter: merges ALU and LSU results onto the single regfile write port.
// LSU has priority; a colliding ALU result is parked in a 1-entry buffer and is
// guaranteed to drain after at most STARVE_MAX further LSU wins. Output is
// registered (1-cycle latency); wb_dest_wen is a one-cycle pulse.
// Ports:
//  clk, rst                        core clock, asynchronous active-high reset
//  alu_valid/ready, alu_wen/idx/dat  ALU result handshake and payload
//  lsu_valid/ready, lsu_wen/idx/dat  load result handshake and payload
//  wb_dest_wen/idx/dat             registered regfile write port
//  fwd_vld/idx/dat                 decode bypass (only with CORE_WB_FWD_EN, else 0)
// Optional feature macro: CORE_WB_FWD_EN.
module core_wb_arbiter
  import core_wb_arbiter_pkg::*;
#(
  parameter int XLEN       = CORE_XLEN,
  parameter int RFIDX_W    = CORE_RFIDX_WIDTH,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  logic               alu_wen,
  input  logic [RFIDX_W-1:0] alu_idx,
  input  logic [XLEN-1:0]    alu_dat,
  input  logic               lsu_valid,
  output logic               lsu_ready,
  input  logic               lsu_wen,
  input  logic [RFIDX_W-1:0] lsu_idx,
  input  logic [XLEN-1:0]    lsu_dat,
  output logic               wb_dest_wen,
  output logic [RFIDX_W-1:0] wb_dest_idx,
  output logic [XLEN-1:0]    wb_dest_dat,
  output logic               fwd_vld,
  output logic [RFIDX_W-1:0] fwd_idx,
  output logic [XLEN-1:0]    fwd_dat
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  wb_state_e          state_q, state_d;
  logic [3:0]         starve_cnt_q, starve_cnt_d;
  logic               wb_wen_q;
  logic [RFIDX_W-1:0] wb_idx_q;
  logic [XLEN-1:0]    wb_dat_q;

  logic               buf_wen, buf_load, buf_clear;
  logic [RFIDX_W-1:0] buf_idx;
  logic [XLEN-1:0]    buf_dat;

  logic               sel_wen;
  logic [RFIDX_W-1:0] sel_idx;
  logic [XLEN-1:0]    sel_dat;
  logic               wr_en;
  logic               alu_fire, lsu_fire;

  // Readies depend on state only, so no valid->ready combinational path exists.
  assign alu_ready = (state_q == WB_ST_EMPTY);
  assign lsu_ready = !((state_q == WB_ST_HELD) && (starve_cnt_q == STARVE_LIM));
  assign alu_fire  = alu_valid && alu_ready;
  assign lsu_fire  = lsu_valid && lsu_ready;

  core_wb_skid #(
    .XLEN   (XLEN),
    .RFIDX_W(RFIDX_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load_i (buf_load),
    .clear_i(buf_clear),
    .wen_i  (alu_wen),
    .idx_i  (alu_idx),
    .dat_i  (alu_dat),
    .wen_o  (buf_wen),
    .idx_o  (buf_idx),
    .dat_o  (buf_dat)
  );

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    sel_wen      = 1'b0;
    sel_idx      = '0;
    sel_dat      = '0;
    buf_load     = 1'b0;
    buf_clear    = 1'b0;
    case (state_q)
      WB_ST_EMPTY: begin
        if (lsu_fire) begin
          sel_wen = lsu_wen;
          sel_idx = lsu_idx;
          sel_dat = lsu_dat;
          if (alu_fire) begin
            // Collision: LSU wins, ALU result is parked.
            buf_load     = 1'b1;
            state_d      = WB_ST_HELD;
            starve_cnt_d = '0;
          end
        end else if (alu_fire) begin
          sel_wen = alu_wen;
          sel_idx = alu_idx;
          sel_dat = alu_dat;
        end
      end
      WB_ST_HELD: begin
        if (lsu_fire) begin
          sel_wen = lsu_wen;
          sel_idx = lsu_idx;
          sel_dat = lsu_dat;
          if (starve_cnt_q != STARVE_LIM) starve_cnt_d = starve_cnt_q + 4'd1;
        end else begin
          // No LSU (or LSU throttled by starvation): drain the buffer.
          sel_wen      = buf_wen;
          sel_idx      = buf_idx;
          sel_dat      = buf_dat;
          buf_clear    = 1'b1;
          state_d      = WB_ST_EMPTY;
          starve_cnt_d = '0;
        end
      end
      default: begin
        state_d      = WB_ST_EMPTY;
        starve_cnt_d = '0;
      end
    endcase
  end

  // Writes to x0 or with wen=0 still consume the slot but never pulse the regfile.
  assign wr_en = sel_wen && (sel_idx != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= WB_ST_EMPTY;
      starve_cnt_q <= '0;
      wb_wen_q     <= 1'b0;
      wb_idx_q     <= '0;
      wb_dat_q     <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      wb_wen_q     <= wr_en;
      // idx/dat keep their last written value while no write occurs.
      if (wr_en) begin
        wb_idx_q <= sel_idx;
        wb_dat_q <= sel_dat;
      end
    end
  end

  assign wb_dest_wen = wb_wen_q;
  assign wb_dest_idx = wb_idx_q;
  assign wb_dest_dat = wb_dat_q;

`ifdef CORE_WB_FWD_EN
  // The buffered entry is younger than anything already in the regfile path,
  // so it takes precedence over the registered write.
  always_comb begin
    fwd_vld = 1'b0;
    fwd_idx = '0;
    fwd_dat = '0;
    if ((state_q == WB_ST_HELD) && buf_wen && (buf_idx != '0)) begin
      fwd_vld = 1'b1;
      fwd_idx = buf_idx;
      fwd_dat = buf_dat;
    end else if (wb_wen_q) begin
      fwd_vld = 1'b1;
      fwd_idx = wb_idx_q;
      fwd_dat = wb_dat_q;
    end
  end
`else
  assign fwd_vld = 1'b0;
  assign fwd_idx = '0;
  assign fwd_dat = '0;
`endif

endmodule

// File: tb/tb_core_wb_arbiter.sv
module tb_core_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0, alu_wen = 1'b0;
  logic [4:0]  alu_idx = '0;
  logic [31:0] alu_dat = '0;
  logic        lsu_valid = 1'b0, lsu_wen = 1'b0;
  logic [4:0]  lsu_idx = '0;
  logic [31:0] lsu_dat = '0;
  logic        alu_ready, lsu_ready;
  logic        wb_dest_wen, fwd_vld;
  logic [4:0]  wb_dest_idx, fwd_idx;
  logic [31:0] wb_dest_dat, fwd_dat;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] dat;
  } wr_t;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  core_wb_arbiter #(.XLEN(32), .RFIDX_W(5), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_wen    (alu_wen),
    .alu_idx    (alu_idx),
    .alu_dat    (alu_dat),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_wen    (lsu_wen),
    .lsu_idx    (lsu_idx),
    .lsu_dat    (lsu_dat),
    .wb_dest_wen(wb_dest_wen),
    .wb_dest_idx(wb_dest_idx),
    .wb_dest_dat(wb_dest_dat),
    .fwd_vld    (fwd_vld),
    .fwd_idx    (fwd_idx),
    .fwd_dat    (fwd_dat)
  );

  // Monitor: every regfile write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && wb_dest_wen) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected act idx=%0d dat=%h req none", wb_dest_idx, wb_dest_dat);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (wb_dest_idx !== e.idx || wb_dest_dat !== e.dat) begin
          errors++;
          $display("FAIL wb_write act idx=%0d dat=%h req idx=%0d dat=%h",
                   wb_dest_idx, wb_dest_dat, e.idx, e.dat);
        end else begin
          $display("wb write idx=%0d dat=%h", wb_dest_idx, wb_dest_dat);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  task automatic push(input logic [4:0] idx, input logic [31:0] dat);
    wr_t e;
    e.idx = idx;
    e.dat = dat;
    exp_q.push_back(e);
  endtask

  // One cycle: drive both sources, check readies, advance past the edge.
  task automatic cyc(input logic av, input logic aw, input logic [4:0] ai, input logic [31:0] ad,
                     input logic lv, input logic lw, input logic [4:0] li, input logic [31:0] ld,
                     input logic ear, input logic elr, input string tag);
    alu_valid = av; alu_wen = aw; alu_idx = ai; alu_dat = ad;
    lsu_valid = lv; lsu_wen = lw; lsu_idx = li; lsu_dat = ld;
    #1;
    chk({tag, "_alu_ready"}, {31'd0, alu_ready}, {31'd0, ear});
    chk({tag, "_lsu_ready"}, {31'd0, lsu_ready}, {31'd0, elr});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ear, input logic elr, input string tag);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, ear, elr, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout act=running req=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen", {31'd0, wb_dest_wen}, 32'd0);
    chk("rst_idx", {27'd0, wb_dest_idx}, 32'd0);
    chk("rst_dat", wb_dest_dat, 32'd0);
    chk("rst_fwd_vld", {31'd0, fwd_vld}, 32'd0);
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: ALU only
    push(5'd5, 32'h11);
    cyc(1'b1, 1'b1, 5'd5, 32'h11, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, "t1");
`ifdef CORE_WB_FWD_EN
    chk("t1_fwd_vld", {31'd0, fwd_vld}, 32'd1);
    chk("t1_fwd_idx", {27'd0, fwd_idx}, 32'd5);
    chk("t1_fwd_dat", fwd_dat, 32'h11);
`else
    chk("t1_fwd_vld", {31'd0, fwd_vld}, 32'd0);
    chk("t1_fwd_dat", fwd_dat, 32'd0);
`endif
    idle(1'b1, 1'b1, "t1_idle");

    // 2 + 6: collision, LSU first, buffered ALU next; bypass shows buffer while HELD
    push(5'd7, 32'hB);
    push(5'd3, 32'hA);
    cyc(1'b1, 1'b1, 5'd3, 32'hA, 1'b1, 1'b1, 5'd7, 32'hB, 1'b1, 1'b1, "t2_n");
`ifdef CORE_WB_FWD_EN
    chk("t6_fwd_vld", {31'd0, fwd_vld}, 32'd1);
    chk("t6_fwd_idx", {27'd0, fwd_idx}, 32'd3);
    chk("t6_fwd_dat", fwd_dat, 32'hA);
`else
    chk("t6_fwd_vld", {31'd0, fwd_vld}, 32'd0);
    chk("t6_fwd_idx", {27'd0, fwd_idx}, 32'd0);
    chk("t6_fwd_dat", fwd_dat, 32'd0);
`endif
    idle(1'b0, 1'b1, "t2_n1");
    idle(1'b1, 1'b1, "t2_n2");
    chk("t2_idx_hold", {27'd0, wb_dest_idx}, 32'd3);
    chk("t2_dat_hold", wb_dest_dat, 32'hA);

    // 3: starvation with STARVE_MAX=4
    push(5'd10, 32'h100);
    cyc(1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 1'b1, 5'd10, 32'h100, 1'b1, 1'b1, "t3_cap");
    for (int k = 0; k < 4; k++) begin
      push(5'(11 + k), 32'h200 + 32'(k));
      cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'(11 + k), 32'h200 + 32'(k), 1'b0, 1'b1, "t3_lsu");
    end
    push(5'd9, 32'h99);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd20, 32'h20, 1'b0, 1'b0, "t3_starve");
    push(5'd20, 32'h20);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd20, 32'h20, 1'b1, 1'b1, "t3_resume");

    // 4: writes to x0 / wen=0 handshake but never pulse
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, "t4_x0");
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd6, 32'h66, 1'b1, 1'b1, "t4_nowen");
    cyc(1'b1, 1'b0, 5'd8, 32'h88, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, "t4_alu_nowen");
    idle(1'b1, 1'b1, "t4_idle");
    chk("t4_no_pulse", {31'd0, wb_dest_wen}, 32'd0);

    // 5: asynchronous reset while HELD; the buffered entry must never appear
    cyc(1'b1, 1'b1, 5'd3, 32'hA, 1'b1, 1'b1, 5'd7, 32'hB, 1'b1, 1'b1, "t5_cap");
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_wen", {31'd0, wb_dest_wen}, 32'd0);
    chk("t5_idx", {27'd0, wb_dest_idx}, 32'd0);
    chk("t5_dat", wb_dest_dat, 32'd0);
    chk("t5_fwd_vld", {31'd0, fwd_vld}, 32'd0);
    chk("t5_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("t5_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1'b1, 1'b1, "t5_post0");
    idle(1'b1, 1'b1, "t5_post1");
    idle(1'b1, 1'b1, "t5_post2");

    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
